mac_operand_feeder: RTL and testbench
=====================================

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, operand-pair FIFO depth (power of two).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles waiting for mac_done.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  host pushes one operand pair.
REQ-006 SHALL have port wr_a / wr_b  input  4 each  operand pair written.
REQ-007 SHALL have port fifo_full / fifo_empty  output  1 each  FIFO status.
REQ-008 SHALL have port start  input  1  begin draining FIFO into the MAC.
REQ-009 SHALL have port busy  output  1  high in any state except IDLE.
REQ-010 SHALL have port mac_go  output  1  one-cycle issue strobe to MAC.
REQ-011 SHALL have port mac_a / mac_b  output  4 each  operands to MAC.
REQ-012 SHALL have port mac_done  input  1  MAC completion strobe.
REQ-013 SHALL have port mac_out  input  12  MAC accumulated result.
REQ-014 SHALL have port result  output  12  last captured mac_out.
REQ-015 SHALL have port result_valid  output  1  one-cycle pulse per capture.
REQ-016 SHALL have port pair_count  output  8  pairs completed in current batch.
REQ-017 SHALL have port batch_done  output  1  one-cycle pulse at end of batch.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, CAPTURE, FINISH.
REQ-019 IDLE: start=1 and FIFO non-empty -> ISSUE, pair_count cleared; start=1 and FIFO empty -> FINISH; start while busy SHALL be ignored.
REQ-020 ISSUE: mac_go=1 for exactly one cycle, mac_a/mac_b = FIFO head, head popped same cycle -> WAIT.
REQ-021 mac_a/mac_b SHALL hold the issued pair stable until the cycle after mac_done is sampled.
REQ-022 WAIT: mac_done=1 -> CAPTURE with result<=mac_out; mac_done in any other state SHALL be ignored.
REQ-023 CAPTURE: result_valid=1 one cycle, pair_count+1 (saturating at 255); FIFO non-empty -> ISSUE, else -> FINISH.
REQ-024 FINISH: batch_done=1 one cycle -> IDLE.
REQ-025 Latency: start at edge N -> mac_go high in cycle N+1; mac_done at edge M -> result_valid high in cycle M+1.
REQ-026 wr_en when full SHALL be dropped, FIFO unchanged; wr_en and pop in same cycle SHALL both take effect (including when full).
REQ-027 Pairs written during a batch SHALL be issued in the same batch if present when CAPTURE evaluates emptiness.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; full/empty via extra pointer bit.

Reset
REQ-029 rst SHALL force IDLE, empty FIFO, mac_go=0, mac_a=mac_b=0, result=0, result_valid=0, pair_count=0, batch_done=0, timeout_err=0.
REQ-030 rst mid-batch SHALL abort without batch_done; subsequent mac_done ignored.

Configuration
REQ-031 Macro MAC_OPERAND_FEEDER_TIMEOUT_EN defined: output timeout_err (1 bit) added; WAIT counts cycles, at TIMEOUT cycles without mac_done -> FINISH with timeout_err set sticky until next start or rst, remaining FIFO pairs retained.
REQ-032 Macro undefined: no counter, no timeout_err port, WAIT waits indefinitely.

Verification
REQ-033 Push (12,6), start, mac_done 3 cycles after mac_go with mac_out=72 -> one mac_go, mac_a=12, mac_b=6, result=72, result_valid 1 cycle, pair_count=1, batch_done 1 cycle.
REQ-034 Push (i,2i+1) i=0..7, start, answer each go -> 8 mac_go pulses in order, fifo_full high after 8th push, 9th push dropped, pair_count=8.
REQ-035 Start with empty FIFO -> no mac_go, batch_done pulse one cycle later, pair_count=0.
REQ-036 Assert rst during WAIT of 2nd of 3 pairs -> all outputs at reset values next cycle, fifo_empty=1, no batch_done.
REQ-037 TIMEOUT_EN with TIMEOUT=64, never assert mac_done -> timeout_err=1 and batch_done 64 cycles after mac_go; undefined: busy stays 1.
REQ-038 Extra mac_done pulse in IDLE -> result and result_valid unchanged.

Source files
------------

// File: rtl/mac_operand_feeder_if.sv
// Issue/complete bus between the operand feeder and a multiply-accumulate unit.
// The feeder is the master: it drives the strobe and operands, the MAC answers with done/result.
interface mac_operand_feeder_if;
  logic        mac_go;
  logic [3:0]  mac_a;
  logic [3:0]  mac_b;
  logic        mac_done;
  logic [11:0] mac_out;

  modport master (output mac_go, mac_a, mac_b, input mac_done, mac_out);
  modport slave  (input mac_go, mac_a, mac_b, output mac_done, mac_out);
endinterface

// File: rtl/mac_operand_feeder.sv
// Buffers host operand pairs in a FIFO and drains them one at a time into a MAC, capturing each result.
// Optional WAIT watchdog and timeout_err output are enabled by defining MAC_OPERAND_FEEDER_TIMEOUT_EN.
module mac_operand_feeder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_a,
  input  logic [3:0]            wr_b,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  input  logic                  start,
  output logic                  busy,
  mac_operand_feeder_if.master  mac,
  output logic [11:0]           result,
  output logic                  result_valid,
  output logic [7:0]            pair_count,
`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic                  batch_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, FINISH} state_t;

  state_t      state, state_n;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  head;
  logic [7:0]  issued;
  logic        push, pop;
  logic        timed_out;

  // Extra pointer bit separates the full case from the empty case when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign pop        = (state == ISSUE) && !fifo_empty;
  assign push       = wr_en && (!fifo_full || pop);

  // NOTE: the storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {wr_a, wr_b};
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // wait_cnt counts cycles since mac_go, so FINISH lands TIMEOUT cycles after the issue strobe.
  assign timed_out = (state == WAIT) && !mac.mac_done && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= CW'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == IDLE && start) timeout_err <= 1'b0;
      else if (timed_out)         timeout_err <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: state_n gets its default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = fifo_empty ? FINISH : ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (mac.mac_done) state_n = CAPTURE;
               else if (timed_out) state_n = FINISH;
      CAPTURE: state_n = fifo_empty ? FINISH : ISSUE;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued     <= '0;
      result     <= '0;
      pair_count <= '0;
    end else begin
      if (state == ISSUE) issued <= head;
      if (state == WAIT && mac.mac_done) result <= mac.mac_out;
      if (state == IDLE && start) pair_count <= '0;
      else if (state == CAPTURE && pair_count != 8'hFF) pair_count <= pair_count + 1'b1;
    end
  end

  // Operands show the FIFO head during the issue cycle and the held copy afterwards.
  assign mac.mac_go    = (state == ISSUE);
  assign mac.mac_a     = (state == ISSUE) ? head[7:4] : issued[7:4];
  assign mac.mac_b     = (state == ISSUE) ? head[3:0] : issued[3:0];
  assign busy          = (state != IDLE);
  assign result_valid  = (state == CAPTURE);
  assign batch_done    = (state == FINISH);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: directed steps plus randomized batches against a queue model.
// Define MAC_OPERAND_FEEDER_TIMEOUT_EN to exercise the watchdog variant.
module tb_mac_operand_feeder;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst, wr_en, start;
  logic [3:0]  wr_a, wr_b;
  logic        fifo_full, fifo_empty, busy;
  logic [11:0] result;
  logic        result_valid, batch_done;
  logic [7:0]  pair_count;
`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
  logic        timeout_err;
`endif

  mac_operand_feeder_if mac_bus ();

  mac_operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_a         (wr_a),
    .wr_b         (wr_b),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .start        (start),
    .busy         (busy),
    .mac          (mac_bus),
    .result       (result),
    .result_valid (result_valid),
    .pair_count   (pair_count),
`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
    .timeout_err  (timeout_err),
`endif
    .batch_done   (batch_done)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  q[$];          // model FIFO contents, {a,b}
  int          exp_count;
  logic [11:0] exp_result;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_push(input logic [3:0] a, input logic [3:0] b);
    if (q.size() < DEPTH) q.push_back({a, b});
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    wr_en = 1'b1; wr_a = a; wr_b = b;
    model_push(a, b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_empty"}, fifo_empty, q.size() == 0);
    check({tag, "_full"},  fifo_full,  q.size() == DEPTH);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_go"},     mac_bus.mac_go, 0);
    check({tag, "_a"},      mac_bus.mac_a, 0);
    check({tag, "_b"},      mac_bus.mac_b, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_rv"},     result_valid, 0);
    check({tag, "_count"},  pair_count, 0);
    check({tag, "_bdone"},  batch_done, 0);
    check({tag, "_empty"},  fifo_empty, 1);
    check({tag, "_full"},   fifo_full, 0);
`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
    check({tag, "_terr"},   timeout_err, 0);
`endif
  endtask

  // Runs one batch from IDLE. Delay is cycles in WAIT before mac_done; out_val < 0 means random result.
  // abort_idx >= 0 asserts rst in WAIT of that pair instead of answering it.
  task automatic run_batch(input string tag, input int min_d, input int max_d,
                           input bit push_during, input int out_val, input int abort_idx);
    logic [7:0] pair;
    bit         pushed_on_issue = 0;
    int         idx = 0;
    exp_count = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
    check({tag, "_terr_clr"}, timeout_err, 0);
`endif
    while (q.size() > 0) begin
      check({tag, "_go"}, mac_bus.mac_go, 1);
      check({tag, "_a"},  mac_bus.mac_a, q[0][7:4]);
      check({tag, "_b"},  mac_bus.mac_b, q[0][3:0]);
      pair = q.pop_front();
      if (push_during && !pushed_on_issue) begin
        wr_en = 1'b1; wr_a = 4'($urandom); wr_b = 4'($urandom);
        model_push(wr_a, wr_b);
        pushed_on_issue = 1;
      end
      step();
      wr_en = 1'b0;
      check({tag, "_go_low"}, mac_bus.mac_go, 0);
      repeat ($urandom_range(min_d, max_d)) begin
        if (push_during && $urandom_range(0, 1) == 1) begin
          wr_en = 1'b1; wr_a = 4'($urandom); wr_b = 4'($urandom);
          model_push(wr_a, wr_b);
        end
        step();
        wr_en = 1'b0;
      end
      check({tag, "_hold"}, {mac_bus.mac_a, mac_bus.mac_b}, pair);
      if (idx == abort_idx) begin
        rst = 1'b1;
        step();
        q.delete();
        exp_result = '0;
        check_reset({tag, "_abort"});
        rst = 1'b0;
        return;
      end
      mac_bus.mac_done = 1'b1;
      mac_bus.mac_out  = (out_val < 0) ? 12'($urandom_range(0, 4095)) : 12'(out_val);
      exp_result = mac_bus.mac_out;
      step();
      mac_bus.mac_done = 1'b0;
      check({tag, "_rv"},     result_valid, 1);
      check({tag, "_result"}, result, exp_result);
      check({tag, "_hold2"},  {mac_bus.mac_a, mac_bus.mac_b}, pair);
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      step();
      check({tag, "_count"},  pair_count, exp_count);
      check({tag, "_rv_low"}, result_valid, 0);
      idx++;
    end
    check({tag, "_bdone"},  batch_done, 1);
    check({tag, "_no_go"},  mac_bus.mac_go, 0);
    check({tag, "_count"},  pair_count, exp_count);
    step();
    check({tag, "_bdone_low"}, batch_done, 0);
    check({tag, "_idle"},   busy, 0);
    check_status(tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; wr_a = '0; wr_b = '0;
    mac_bus.mac_done = 1'b0; mac_bus.mac_out = '0;
    exp_result = '0;
    repeat (2) step();
    check_reset("reset");
    rst = 1'b0;
    step();
    check_reset("post_reset");

    // Start with nothing queued: straight to FINISH.
    run_batch("empty", 0, 0, 0, -1, -1);

    // Single pair (12,6), mac_done three cycles after mac_go.
    push(4'd12, 4'd6);
    check_status("one_push");
    run_batch("single", 2, 2, 0, 72, -1);

    // Stray mac_done while idle must not disturb the captured result.
    mac_bus.mac_done = 1'b1; mac_bus.mac_out = 12'hABC;
    step();
    mac_bus.mac_done = 1'b0;
    check("stray_rv", result_valid, 0);
    check("stray_result", result, exp_result);
    check("stray_busy", busy, 0);

    // Fill to DEPTH, then one dropped push.
    for (int i = 0; i < DEPTH; i++) push(4'(i), 4'(2 * i + 1));
    check("fill_full", fifo_full, 1);
    push(4'hF, 4'hF);
    check_status("drop");
    run_batch("fill", 1, 1, 0, -1, -1);

    // Randomized batches with host writes during the batch; first one starts full.
    for (int r = 0; r < 5; r++) begin
      int n = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) push(4'($urandom), 4'($urandom));
      run_batch($sformatf("rand%0d", r), 0, 4, 1, -1, -1);
    end

    // MAC never answers.
    push(4'd3, 4'd5);
    push(4'd7, 4'd9);
    start = 1'b1;
    step();
    start = 1'b0;
    check("hang_go", mac_bus.mac_go, 1);
    void'(q.pop_front());
    step();
`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
    repeat (TIMEOUT - 2) step();
    check("to_early", batch_done, 0);
    step();
    check("to_bdone", batch_done, 1);
    check("to_err", timeout_err, 1);
    step();
    check("to_idle", busy, 0);
    check("to_sticky", timeout_err, 1);
    check_status("to_retained");
    run_batch("after_to", 0, 2, 0, -1, -1);
`else
    repeat (100) step();
    check("hang_busy", busy, 1);
    check("hang_bdone", batch_done, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    exp_result = '0;
    check_reset("hang_reset");
`endif

    // Reset during WAIT of the second of three pairs, then a late mac_done.
    for (int i = 0; i < 3; i++) push(4'($urandom), 4'($urandom));
    run_batch("abort", 0, 2, 0, -1, 1);
    step();
    mac_bus.mac_done = 1'b1; mac_bus.mac_out = 12'h555;
    step();
    mac_bus.mac_done = 1'b0;
    check("late_done_rv", result_valid, 0);
    check("late_done_result", result, 0);
    check("late_done_bdone", batch_done, 0);
    check("late_done_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
